// File: rtl/cache_pkg.sv
// Shared cache definitions: geometry defaults, replacement-mode encoding, LFSR constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef CACHE_E
`define CACHE_E 4
`endif
`ifndef CACHE_S
`define CACHE_S 4
`endif

package cache_pkg;

    localparam int CACHE_E = `CACHE_E;   // ways per set
    localparam int CACHE_S = `CACHE_S;   // number of sets

    typedef enum logic [1:0] {
        MODE_LRU     = 2'd0,
        MODE_FIFO    = 2'd1,
        MODE_RANDOM  = 2'd2,
        MODE_LRU_ALT = 2'd3    // reserved encoding, behaves as LRU
    } replace_mode_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 (1-based) -> state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Fibonacci step: shift left, feedback parity of the tapped bits enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/replace_policy_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running, used as the RANDOM replacement source.
// Latency: advances one step per clock; value_o is the registered state.
// Backpressure: none, never stalls.
// Ports: clk_i clock, rst_i async active-high reset (loads seed), value_o current state.
module lfsr16
    import cache_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] value_o
);

    logic [15:0] r_state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= LFSR_SEED;
        end else begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign value_o = r_state;

endmodule

// File: rtl/replace_policy.sv
// Cache victim selection (LRU / FIFO / RANDOM) with per-set valid, age and FIFO state.
// Latency: victim_o is combinational from registered state; updates visible the cycle after.
// Backpressure: none, accepts one update per cycle.
// Ports: clk_i/rst_i clock and async active-high reset; mode_i policy; flush_i invalidate all;
//        query_set_i -> victim_o; update_en_i/update_set_i/update_line_i/update_fill_i access record.
`ifndef CACHE_E
`define CACHE_E 4
`endif
`ifndef CACHE_S
`define CACHE_S 4
`endif

module replace_policy
    import cache_pkg::*;
#(
    parameter  int SET_SIZE  = `CACHE_E,
    parameter  int SET_NUM   = `CACHE_S,
    localparam int SEL_WIDTH = $clog2(SET_SIZE),
    localparam int SET_WIDTH = (SET_NUM > 1) ? $clog2(SET_NUM) : 1
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           mode_i,
    input  logic                 flush_i,
    input  logic [SET_WIDTH-1:0] query_set_i,
    output logic [SEL_WIDTH-1:0] victim_o,
    input  logic                 update_en_i,
    input  logic [SET_WIDTH-1:0] update_set_i,
    input  logic [SEL_WIDTH-1:0] update_line_i,
    input  logic                 update_fill_i
);

    replace_mode_t          w_mode;
    logic [15:0]            w_lfsr;
    logic [15-SEL_WIDTH:0]  w_lfsr_unused;
    logic [SEL_WIDTH-1:0]   w_rand;
    logic                   w_line_ok;
    logic [SEL_WIDTH-1:0]   w_set_victim [SET_NUM];

    assign w_mode = replace_mode_t'(mode_i);

    lfsr16 u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .value_o (w_lfsr)
    );

    // Only the low bits select a way; the rest of the LFSR state is deliberately dropped.
    assign w_lfsr_unused = w_lfsr[15:SEL_WIDTH];
    assign w_rand        = SEL_WIDTH'(32'(w_lfsr[SEL_WIDTH-1:0]) % 32'(SET_SIZE));

    // Way indices beyond SET_SIZE (non power-of-two sets) are dropped. Set range is
    // implicit: only generated sets can match update_set_i.
    assign w_line_ok = ({1'b0, update_line_i} < (SEL_WIDTH+1)'(SET_SIZE));

    for (genvar s = 0; s < SET_NUM; s++) begin : g_set
        logic [SET_SIZE-1:0]  r_valid;
        logic [SEL_WIDTH-1:0] r_age [SET_SIZE];
        logic [SEL_WIDTH-1:0] r_fifo;
        logic                 w_upd;
        logic [SEL_WIDTH-1:0] w_old_age;
        logic                 w_any_inv;
        logic [SEL_WIDTH-1:0] w_inv_way;
        logic [SEL_WIDTH-1:0] w_lru_way;
        logic [SEL_WIDTH-1:0] w_policy_way;

        assign w_upd = update_en_i && w_line_ok && (update_set_i == SET_WIDTH'(s));

        // Age the accessed way held before this access.
        always_comb begin
            w_old_age = '0;
            for (int w = 0; w < SET_SIZE; w++) begin
                if (update_line_i == SEL_WIDTH'(w)) begin
                    w_old_age = r_age[w];
                end
            end
        end

        // Flush restores exactly the reset image but leaves the LFSR running.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_valid <= '0;
                r_fifo  <= '0;
                for (int w = 0; w < SET_SIZE; w++) begin
                    r_age[w] <= SEL_WIDTH'(w);
                end
            end else if (flush_i) begin
                r_valid <= '0;
                r_fifo  <= '0;
                for (int w = 0; w < SET_SIZE; w++) begin
                    r_age[w] <= SEL_WIDTH'(w);
                end
            end else if (w_upd) begin
                // Accessed way becomes youngest; only ways younger than it shift up,
                // so the ages remain a permutation.
                for (int w = 0; w < SET_SIZE; w++) begin
                    if (update_line_i == SEL_WIDTH'(w)) begin
                        r_age[w] <= '0;
                        if (update_fill_i) begin
                            r_valid[w] <= 1'b1;
                        end
                    end else if (r_age[w] < w_old_age) begin
                        r_age[w] <= r_age[w] + 1'b1;
                    end
                end
                if (update_fill_i && (r_fifo == update_line_i)) begin
                    r_fifo <= (r_fifo == SEL_WIDTH'(SET_SIZE - 1)) ? '0 : r_fifo + 1'b1;
                end
            end
        end

        // Lowest-index invalid way (scan from the top so the lowest wins) and oldest way.
        always_comb begin
            w_any_inv = 1'b0;
            w_inv_way = '0;
            w_lru_way = '0;
            for (int w = SET_SIZE - 1; w >= 0; w--) begin
                if (!r_valid[w]) begin
                    w_any_inv = 1'b1;
                    w_inv_way = SEL_WIDTH'(w);
                end
            end
            for (int w = 0; w < SET_SIZE; w++) begin
                if (r_age[w] == SEL_WIDTH'(SET_SIZE - 1)) begin
                    w_lru_way = SEL_WIDTH'(w);
                end
            end
        end

        always_comb begin
            case (w_mode)
                MODE_FIFO:   w_policy_way = r_fifo;
                MODE_RANDOM: w_policy_way = w_rand;
                default:     w_policy_way = w_lru_way;
            endcase
        end

        assign w_set_victim[s] = w_any_inv ? w_inv_way : w_policy_way;
    end

    always_comb begin
        victim_o = '0;
        for (int s = 0; s < SET_NUM; s++) begin
            if (query_set_i == SET_WIDTH'(s)) begin
                victim_o = w_set_victim[s];
            end
        end
    end

endmodule

// File: tb/tb_replace_policy.sv
module tb_replace_policy;

    localparam int WAYS = 4;
    localparam int SETS = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] mode_i;
    logic       flush_i;
    logic [1:0] query_set_i;
    logic [1:0] victim_o;
    logic [1:0] victim3_o;
    logic       update_en_i;
    logic [1:0] update_set_i;
    logic [1:0] update_line_i;
    logic       update_fill_i;

    always #5 clk_i = ~clk_i;

    replace_policy #(.SET_SIZE(WAYS), .SET_NUM(SETS)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .flush_i(flush_i),
        .query_set_i(query_set_i), .victim_o(victim_o),
        .update_en_i(update_en_i), .update_set_i(update_set_i),
        .update_line_i(update_line_i), .update_fill_i(update_fill_i)
    );

    // Three-set instance: updates aimed at set 3 are out of range and must be ignored.
    replace_policy #(.SET_SIZE(WAYS), .SET_NUM(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .flush_i(flush_i),
        .query_set_i(query_set_i), .victim_o(victim3_o),
        .update_en_i(update_en_i), .update_set_i(update_set_i),
        .update_line_i(update_line_i), .update_fill_i(update_fill_i)
    );

    // Reference model: recency list per set (front = most recent), valid flags, FIFO pointer.
    int          m_order [SETS][$];
    bit          m_valid [SETS][WAYS];
    int          m_ptr   [SETS];
    logic [15:0] m_lfsr;

    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] spec_lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_order[s] = {};
            for (int w = 0; w < WAYS; w++) begin
                m_order[s].push_back(w);
                m_valid[s][w] = 1'b0;
            end
            m_ptr[s] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_touch(input int s, input int l);
        int idx;
        idx = 0;
        for (int i = 0; i < m_order[s].size(); i++) begin
            if (m_order[s][i] == l) idx = i;
        end
        m_order[s].delete(idx);
        m_order[s].push_front(l);
    endtask

    task automatic model_edge();
        int s;
        int l;
        if (rst_i) begin
            model_reset();
            return;
        end
        m_lfsr = spec_lfsr_next(m_lfsr);
        if (flush_i) begin
            model_clear();
        end else if (update_en_i) begin
            s = int'(update_set_i);
            l = int'(update_line_i);
            model_touch(s, l);
            if (update_fill_i) begin
                m_valid[s][l] = 1'b1;
                if (m_ptr[s] == l) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
        end
    endtask

    function automatic int model_victim(input int s, input int mode);
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w]) return w;
        end
        case (mode)
            1:       return m_ptr[s];
            2:       return int'(m_lfsr[1:0]) % WAYS;
            default: return m_order[s][m_order[s].size() - 1];
        endcase
    endfunction

    task automatic check(input string name, input logic [1:0] act, input int exp);
        checks++;
        if (int'(act) !== exp) begin
            errors++;
            $display("FAIL %s: got victim %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int mode, input int fl, input int en, input int set,
                         input int line, input int fill, input int q);
        mode_i        = 2'(mode);
        flush_i       = 1'(fl);
        update_en_i   = 1'(en);
        update_set_i  = 2'(set);
        update_line_i = 2'(line);
        update_fill_i = 1'(fill);
        query_set_i   = 2'(q);
    endtask

    // One rising edge, model follows the inputs seen at that edge, sample 1 time unit later.
    task automatic cyc();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    typedef struct {
        int mode; int fl; int en; int set; int line; int fill; int q; int exp;
    } vec_t;

    function automatic vec_t mk(input int mode, input int fl, input int en, input int set,
                                input int line, input int fill, input int q, input int exp);
        vec_t v;
        v.mode = mode; v.fl = fl; v.en = en; v.set = set;
        v.line = line; v.fill = fill; v.q = q; v.exp = exp;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        // mode, flush, en, set, line, fill, query, expected victim after the edge
        tbl[0]  = mk(0, 0, 1, 2, 0, 1, 2, 1);
        tbl[1]  = mk(0, 0, 1, 2, 1, 1, 2, 2);
        tbl[2]  = mk(0, 0, 1, 2, 2, 1, 2, 3);
        tbl[3]  = mk(0, 0, 1, 0, 0, 1, 0, 1);
        tbl[4]  = mk(0, 0, 1, 0, 1, 1, 0, 2);
        tbl[5]  = mk(0, 0, 1, 0, 2, 1, 0, 3);
        tbl[6]  = mk(0, 0, 1, 0, 3, 1, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0, 1);
        tbl[8]  = mk(0, 0, 1, 0, 1, 0, 0, 2);
        tbl[9]  = mk(1, 0, 1, 1, 0, 1, 1, 1);
        tbl[10] = mk(1, 0, 1, 1, 1, 1, 1, 2);
        tbl[11] = mk(1, 0, 1, 1, 2, 1, 1, 3);
        tbl[12] = mk(1, 0, 1, 1, 3, 1, 1, 0);
        tbl[13] = mk(1, 0, 1, 1, 3, 0, 1, 0);
        tbl[14] = mk(1, 0, 1, 1, 2, 0, 1, 0);
        tbl[15] = mk(1, 0, 1, 1, 0, 1, 1, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 1);
        tbl[17] = mk(3, 0, 0, 0, 0, 0, 0, 2);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0);

        // Reset behaviour.
        drive(0, 0, 0, 0, 0, 0, 2);
        rst_i = 1'b1;
        model_reset();
        #1;
        check("reset_victim", victim_o, 0);
        checks++;
        if (u_dut.u_lfsr.value_o !== 16'hACE1) begin
            errors++;
            $display("FAIL lfsr_seed: got %h, want %h", u_dut.u_lfsr.value_o, 16'hACE1);
        end
        @(posedge clk_i);
        #1;
        check("reset_held", victim_o, 0);
        rst_i = 1'b0;
        #1;
        check("post_reset", victim_o, 0);

        // Directed table: fills, LRU hits, FIFO pointer, mode switch.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].mode, tbl[i].fl, tbl[i].en, tbl[i].set, tbl[i].line, tbl[i].fill, tbl[i].q);
            cyc();
            check($sformatf("tbl%0d", i), victim_o, tbl[i].exp);
        end

        // RANDOM on a full set tracks the LFSR low bits every cycle.
        drive(2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("random%0d", i), victim_o, int'(m_lfsr[1:0]));
            cyc();
        end

        // Flush beats a simultaneous update; update visible only after the edge.
        drive(0, 0, 1, 3, 0, 1, 3); cyc();
        drive(0, 0, 1, 3, 1, 1, 3); cyc();
        check("set3_two_fills", victim_o, 2);
        drive(0, 1, 1, 3, 2, 1, 3);
        #1;
        check("pre_update_view", victim_o, 2);
        cyc();
        check("flush_wins", victim_o, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("flush_all_sets", victim_o, 0);

        // Asynchronous reset between edges.
        drive(0, 0, 1, 2, 0, 1, 2); cyc();
        drive(0, 0, 1, 2, 1, 1, 2); cyc();
        check("pre_async_rst", victim_o, 2);
        drive(0, 0, 1, 2, 2, 1, 2);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        check("async_rst", victim_o, 0);
        #2;
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2);
        #1;
        check("after_async_rst", victim_o, 0);

        // Randomized traffic against the model; checks taken before the edge so a
        // same-cycle update to the queried set must not show yet.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3), ($urandom_range(0, 39) == 0) ? 1 : 0,
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 3));
            #1;
            check($sformatf("rand%0d", i), victim_o,
                  model_victim(int'(query_set_i), int'(mode_i)));
            if (query_set_i != 2'd3) begin
                check($sformatf("rand3set%0d", i), victim3_o,
                      model_victim(int'(query_set_i), int'(mode_i)));
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/replace_policy.md
REPLACE_POLICY -- requirements
Module: replace_policy

Interface
REQ-001 SHALL have parameter SET_SIZE, default `CACHE_E, ways per set (>=2).
REQ-002 SHALL have parameter SET_NUM, default `CACHE_S, sets tracked (>=1).
REQ-003 SHALL derive SEL_WIDTH = $clog2(SET_SIZE) and SET_WIDTH = max(1, $clog2(SET_NUM)) as localparams.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 mode_i  input  2  policy select: 0 LRU, 1 FIFO, 2 RANDOM, 3 treated as LRU.
REQ-007 flush_i  input  1  invalidate all ways of all sets.
REQ-008 query_set_i  input  SET_WIDTH  set whose victim is requested.
REQ-009 victim_o  output  SEL_WIDTH  victim way for query_set_i, combinational from registered state.
REQ-010 update_en_i  input  1  record an access this cycle.
REQ-011 update_set_i  input  SET_WIDTH  set of the access.
REQ-012 update_line_i  input  SEL_WIDTH  way accessed.
REQ-013 update_fill_i  input  1  access is a miss fill (way becomes valid).

Function
REQ-014 Per set SHALL hold: valid bit per way, age per way (SEL_WIDTH bits, a permutation of 0..SET_SIZE-1), FIFO pointer (SEL_WIDTH bits).
REQ-015 victim_o SHALL be the lowest-index invalid way of query_set_i whenever any way is invalid, in every mode.
REQ-016 With all ways valid, victim_o SHALL be: LRU -> way with age SET_SIZE-1; FIFO -> FIFO pointer; RANDOM -> LFSR[SEL_WIDTH-1:0] modulo SET_SIZE.
REQ-017 On update_en_i (any mode), accessed way age SHALL become 0 and every way of that set with age below the accessed way's old age SHALL increment by 1; others unchanged (ages stay a permutation).
REQ-018 On update_en_i with update_fill_i, accessed way SHALL become valid; FIFO pointer SHALL advance by 1 only when it equals update_line_i, wrapping SET_SIZE-1 -> 0.
REQ-019 Hits (update_fill_i=0) SHALL NOT change valid bits or FIFO pointer.
REQ-020 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle regardless of mode or update.
REQ-021 update_line_i >= SET_SIZE or update_set_i >= SET_NUM SHALL be ignored (no state change).
REQ-022 Update and query to the same set in one cycle: victim_o SHALL reflect pre-update state; new state visible next cycle.
REQ-023 flush_i SHALL clear all valid bits, restore ages and FIFO pointers to reset values next edge; flush_i wins over a simultaneous update_en_i; LFSR unaffected.
REQ-024 mode_i changes SHALL NOT alter stored state; new policy applies to victim_o in the same cycle.

Reset
REQ-025 While rst_i high: all valid bits 0, age[w] = w for every set, FIFO pointers 0, LFSR = 16'hACE1.
REQ-026 Consequently victim_o SHALL read 0 during and immediately after reset.
REQ-027 Reset asserted mid-operation SHALL override any pending update or flush immediately (asynchronous).

Structure
REQ-028 Mode encoding (enum replace_mode_t), LFSR seed and tap constants SHALL live in shared package cache_pkg alongside existing `CACHE_* parameters.
REQ-029 LFSR SHALL be a sub-module lfsr16 (clk_i, rst_i, value_o); per-set logic SHALL be generate-looped inside replace_policy.
REQ-030 No dynamic arrays, queues or int-typed state; all storage sized by parameters and synthesizable.

Verification (SET_SIZE=4, SET_NUM=4)
REQ-031 Reset, then query set 2 -> victim_o=0; fill ways 0,1,2 of set 2 -> victim_o=3 after the third fill.
REQ-032 LRU: fill set 0 ways 0..3, hit way 0 -> victim_o=1; hit way 1 -> victim_o=2.
REQ-033 FIFO: fill set 1 ways 0..3, hit ways 3,2 -> victim_o=0; fill way 0 -> victim_o=1.
REQ-034 RANDOM, set full: victim_o equals LFSR[1:0] each cycle; first post-reset value matches seed 16'hACE1 -> 1.
REQ-035 Same-cycle flush_i and update_en_i to set 3 -> all ways invalid next cycle, victim_o=0; out-of-range update_set_i -> no state change.
REQ-036 Assert rst_i asynchronously mid-sequence (between edges) -> victim_o=0 before next clock edge.
